// File: rtl/hist_capture.sv
// hist_capture: per-lane pixel histogram with hardware bin clear, single-frame
// capture with read-modify-write forwarding, and a strobe/ack readout port.
module hist_capture #(
  parameter int CHANNELS   = 3,
  parameter int COLORDEPTH = 8,
  parameter int CNT_WIDTH  = 32,
  parameter bit POL_VS     = 1'b1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [CHANNELS*COLORDEPTH-1:0] pix_i,
  input  logic                           dv_i,
  input  logic                           vs_i,
  input  logic                           start_i,
  input  logic                           rd_strobe_i,
  input  logic [COLORDEPTH+1:0]          rd_addr_i,
  output logic [CNT_WIDTH-1:0]           rd_data_o,
  output logic                           rd_ack_o,
  output logic                           rd_err_o,
  output logic                           busy_o,
  output logic                           done_o,
  output logic [31:0]                    pix_count_o
);

  localparam int         NBINS = 2**COLORDEPTH;
  localparam logic [2:0] NCH   = 3'(CHANNELS);

  typedef enum logic [2:0] {CLEAR, IDLE, WAIT_VS, COUNT, DRAIN, DONE} state_t;
  state_t state, nxt_state;

  logic [COLORDEPTH-1:0]         clr_addr;
  logic                          clr_to_wait;
  logic                          vs_int, vs_q, frame_edge;
  logic                          rd_mode, start_ok, rd_ok;
  logic                          vld_p0, vld_p1;
  logic                          rvld_p0, rok_p0;
  logic [1:0]                    rlane_p0;
  logic [CHANNELS*CNT_WIDTH-1:0] rdat_all;
  logic [CNT_WIDTH-1:0]          rd_sel;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] x);
    return (&x) ? x : x + CNT_WIDTH'(1);
  endfunction

  function automatic logic [31:0] sat_inc32(input logic [31:0] x);
    return (&x) ? x : x + 32'd1;
  endfunction

  assign vs_int     = POL_VS ? vs_i : ~vs_i;
  assign frame_edge = vs_int & ~vs_q;
  assign rd_mode    = (state == IDLE) || (state == DONE);
  assign start_ok   = start_i && rd_mode;
  // A start in the same cycle as a strobe takes the read port away, so the read is refused.
  assign rd_ok      = rd_strobe_i && rd_mode && !start_i &&
                      ({1'b0, rd_addr_i[COLORDEPTH+1:COLORDEPTH]} < NCH);
  assign busy_o     = (state == CLEAR) || (state == WAIT_VS) || (state == COUNT) || (state == DRAIN);
  assign done_o     = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= CLEAR;
      clr_addr    <= '0;
      clr_to_wait <= 1'b0;
      vs_q        <= 1'b0;
    end else begin
      state    <= nxt_state;
      vs_q     <= vs_int;
      clr_addr <= (state == CLEAR) ? clr_addr + COLORDEPTH'(1) : '0;
      if (start_ok) clr_to_wait <= 1'b1;
    end
  end

  always_comb begin
    nxt_state = state;
    case (state)
      CLEAR:      if (&clr_addr) nxt_state = clr_to_wait ? WAIT_VS : IDLE;
      IDLE, DONE: if (start_i) nxt_state = CLEAR;
      WAIT_VS:    if (frame_edge) nxt_state = COUNT;
      COUNT:      if (frame_edge) nxt_state = DRAIN;
      DRAIN:      nxt_state = DONE;
      default:    nxt_state = CLEAR;
    endcase
  end

  // Stage p0: pixel/strobe registered, RAM read issued; stage p1: write-back and read response.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p0      <= 1'b0;
      vld_p1      <= 1'b0;
      rvld_p0     <= 1'b0;
      rok_p0      <= 1'b0;
      rd_ack_o    <= 1'b0;
      rd_err_o    <= 1'b0;
      rd_data_o   <= '0;
      pix_count_o <= '0;
    end else begin
      vld_p0   <= (state == COUNT) && dv_i;
      vld_p1   <= vld_p0;
      rvld_p0  <= rd_strobe_i;
      rok_p0   <= rd_ok;
      rd_ack_o <= rvld_p0;
      rd_err_o <= rvld_p0 && !rok_p0;
      if (rvld_p0) rd_data_o <= rok_p0 ? rd_sel : '0;
      if ((state == WAIT_VS) && frame_edge) pix_count_o <= '0;
      else if ((state == COUNT) && dv_i) pix_count_o <= sat_inc32(pix_count_o);
    end
  end

  always_ff @(posedge clk) begin
    rlane_p0 <= rd_addr_i[COLORDEPTH+1:COLORDEPTH];
  end

  always_comb begin
    rd_sel = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (rlane_p0 == 2'(k)) rd_sel = rdat_all[k*CNT_WIDTH +: CNT_WIDTH];
    end
  end

  for (genvar k = 0; k < CHANNELS; k++) begin : g_lane
    logic [CNT_WIDTH-1:0]  mem [NBINS];
    logic [COLORDEPTH-1:0] raddr, bin_p0, bin_p1;
    logic [CNT_WIDTH-1:0]  rdat_p0, cnt_p1, opnd, cnt_nxt;

    assign raddr   = rd_mode ? rd_addr_i[COLORDEPTH-1:0] : pix_i[k*COLORDEPTH +: COLORDEPTH];
    // The RAM read of a bin written on the previous cycle is stale; take the fresh value instead.
    assign opnd    = (vld_p1 && (bin_p1 == bin_p0)) ? cnt_p1 : rdat_p0;
    assign cnt_nxt = sat_inc(opnd);
    assign rdat_all[k*CNT_WIDTH +: CNT_WIDTH] = rdat_p0;

    always_ff @(posedge clk) begin
      bin_p0  <= pix_i[k*COLORDEPTH +: COLORDEPTH];
      bin_p1  <= bin_p0;
      cnt_p1  <= cnt_nxt;
      rdat_p0 <= mem[raddr];
      if (state == CLEAR) mem[clr_addr] <= '0;
      else if (vld_p0) mem[bin_p0] <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_hist_capture.sv
// Randomized bench for hist_capture: frames are checked against an array-based
// histogram model; a second small instance covers saturation and active-low vsync.
`timescale 1ns/1ps
module tb_hist_capture;
  localparam int CH = 3, CD = 8, CW = 32, NB = 256;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst, dv, vs, start, rd_strobe;
  logic [CH*CD-1:0] pix;
  logic [CD+1:0]   rd_addr;
  logic [CW-1:0]   rd_data;
  logic            rd_ack, rd_err, busy, done;
  logic [31:0]     pix_count;

  logic            dv2, vs2, start2, rd_strobe2;
  logic [3:0]      pix2;
  logic [5:0]      rd_addr2;
  logic [3:0]      rd_data2;
  logic            rd_ack2, rd_err2, busy2, done2;
  logic [31:0]     pix_count2;

  hist_capture #(.CHANNELS(CH), .COLORDEPTH(CD), .CNT_WIDTH(CW), .POL_VS(1'b1)) dut (
    .clk(clk), .rst(rst), .pix_i(pix), .dv_i(dv), .vs_i(vs), .start_i(start),
    .rd_strobe_i(rd_strobe), .rd_addr_i(rd_addr), .rd_data_o(rd_data), .rd_ack_o(rd_ack),
    .rd_err_o(rd_err), .busy_o(busy), .done_o(done), .pix_count_o(pix_count));

  hist_capture #(.CHANNELS(1), .COLORDEPTH(4), .CNT_WIDTH(4), .POL_VS(1'b0)) dut_sat (
    .clk(clk), .rst(rst), .pix_i(pix2), .dv_i(dv2), .vs_i(vs2), .start_i(start2),
    .rd_strobe_i(rd_strobe2), .rd_addr_i(rd_addr2), .rd_data_o(rd_data2), .rd_ack_o(rd_ack2),
    .rd_err_o(rd_err2), .busy_o(busy2), .done_o(done2), .pix_count_o(pix_count2));

  int vectors = 0, miscompares = 0;
  int model [CH][NB];
  int model_pix;
  int m2 [16];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < CH; k++)
      for (int b = 0; b < NB; b++) model[k][b] = 0;
    model_pix = 0;
  endtask

  function automatic logic [CH*CD-1:0] gen_pix(input int mode, input int idx);
    logic [CH*CD-1:0] p;
    int seq [6] = '{5, 5, 5, 7, 7, 5};
    p = '0;
    for (int k = 0; k < CH; k++) begin
      if (mode == 0)      p[k*CD +: CD] = 8'(10 * (k + 1));
      else if (mode == 1) p[k*CD +: CD] = (k == 0) ? 8'(seq[idx % 6]) : 8'($urandom_range(0, 255));
      else p[k*CD +: CD] = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 3));
    end
    return p;
  endfunction

  task automatic read1(input logic [CD+1:0] a, input logic [CW-1:0] exp, input bit experr, input string tag);
    rd_strobe = 1'b1; rd_addr = a; @(negedge clk); rd_strobe = 1'b0;
    check({tag, "_early_ack"}, rd_ack, 0);
    @(negedge clk);
    check({tag, "_ack"}, rd_ack, 1);
    check({tag, "_err"}, rd_err, experr);
    check({tag, "_data"}, rd_data, exp);
  endtask

  task automatic read2(input logic [5:0] a, input logic [3:0] exp, input bit experr, input string tag);
    rd_strobe2 = 1'b1; rd_addr2 = a; @(negedge clk); rd_strobe2 = 1'b0;
    check({tag, "_early_ack"}, rd_ack2, 0);
    @(negedge clk);
    check({tag, "_ack"}, rd_ack2, 1);
    check({tag, "_err"}, rd_err2, experr);
    check({tag, "_data"}, rd_data2, exp);
  endtask

  // Back-to-back strobes over every bin plus a few invalid-lane reads.
  task automatic dump_check(input string tag);
    logic [CD+1:0] req [$];
    logic [CD+1:0] a;
    int ln, bn, n;
    for (int k = 0; k < CH; k++)
      for (int b = 0; b < NB; b++) req.push_back({2'(k), 8'(b)});
    for (int i = 0; i < 4; i++) req.push_back({2'd3, 8'($urandom_range(0, 255))});
    n = req.size();
    for (int i = 0; i < n + 2; i++) begin
      if (i >= 2) begin
        a  = req[i-2];
        ln = int'(a[CD+1:CD]);
        bn = int'(a[CD-1:0]);
        check($sformatf("%s_ack_l%0d_b%0d", tag, ln, bn), rd_ack, 1);
        if (ln < CH) begin
          check($sformatf("%s_err_l%0d_b%0d", tag, ln, bn), rd_err, 0);
          check($sformatf("%s_data_l%0d_b%0d", tag, ln, bn), rd_data, 64'(model[ln][bn]));
        end else begin
          check($sformatf("%s_lane3_err", tag), rd_err, 1);
          check($sformatf("%s_lane3_data", tag), rd_data, 0);
        end
      end
      if (i < n) begin rd_strobe = 1'b1; rd_addr = req[i]; end
      else rd_strobe = 1'b0;
      @(negedge clk);
    end
    check({tag, "_ack_idle"}, rd_ack, 0);
  endtask

  task automatic capture(input int mode, input int npix, input bit probe, input bit with_rd, input string tag);
    logic [CH*CD-1:0] p;
    int sent, cyc, t;
    if (with_rd) begin
      start = 1'b1; rd_strobe = 1'b1; rd_addr = {2'd0, 8'd10};
      @(negedge clk); start = 1'b0; rd_strobe = 1'b0;
      check({tag, "_start_busy"}, busy, 1);
      @(negedge clk);
      check({tag, "_startwin_ack"}, rd_ack, 1);
      check({tag, "_startwin_err"}, rd_err, 1);
      check({tag, "_startwin_data"}, rd_data, 0);
    end else begin
      start = 1'b1; @(negedge clk); start = 1'b0;
      check({tag, "_start_busy"}, busy, 1);
    end
    repeat (NB + 4) @(negedge clk);
    check({tag, "_waitvs_busy"}, busy, 1);
    check({tag, "_waitvs_done"}, done, 0);
    model_clear();
    vs = 1'b1; @(negedge clk); vs = 1'b0; repeat (3) @(negedge clk);
    sent = 0; cyc = 0;
    while (sent < npix || (probe && cyc < 8)) begin
      if (probe && cyc == 7) begin
        check({tag, "_busyrd_ack"}, rd_ack, 1);
        check({tag, "_busyrd_err"}, rd_err, 1);
        check({tag, "_busyrd_data"}, rd_data, 0);
      end
      rd_strobe = probe && (cyc == 5);
      rd_addr   = {2'd0, 8'd10};
      p  = gen_pix(mode, sent);
      dv = (sent < npix) && ((mode != 2) || ($urandom_range(0, 3) != 0));
      pix = p;
      if (dv) begin
        for (int k = 0; k < CH; k++) model[k][p[k*CD +: CD]]++;
        model_pix++;
        sent++;
      end
      cyc++;
      @(negedge clk);
    end
    dv = 1'b0; rd_strobe = 1'b0;
    vs = 1'b1; @(negedge clk); vs = 1'b0;
    t = 0;
    while (!done && t < 20) begin @(negedge clk); t++; end
    check({tag, "_done"}, done, 1);
    check({tag, "_busy_off"}, busy, 0);
    check({tag, "_pix_count"}, pix_count, 64'(model_pix));
    dump_check(tag);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, vectors %0d", vectors);
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt, t, n2;
    rst = 1'b1; dv = 1'b0; vs = 1'b0; start = 1'b0; rd_strobe = 1'b0; rd_addr = '0; pix = '0;
    dv2 = 1'b0; vs2 = 1'b1; start2 = 1'b0; rd_strobe2 = 1'b0; rd_addr2 = '0; pix2 = '0;
    @(negedge clk);
    check("rst_ack", rd_ack, 0);
    check("rst_done", done, 0);
    check("rst_pix_count", pix_count, 0);
    check("rst_rd_data", rd_data, 0);
    rst = 1'b0;
    cnt = 0;
    while (busy && cnt < 400) begin cnt++; @(negedge clk); end
    check("rst_clear_cycles", cnt, 256);
    check("rst_idle_done", done, 0);
    check("rst_idle_busy", busy, 0);
    read1({2'd0, 8'h00}, '0, 1'b0, "rst_read");

    // saturating 4-bit counters, active-low vsync
    start2 = 1'b1; @(negedge clk); start2 = 1'b0;
    repeat (20) @(negedge clk);
    vs2 = 1'b0; @(negedge clk); vs2 = 1'b1; repeat (2) @(negedge clk);
    for (int b = 0; b < 16; b++) m2[b] = 0;
    n2 = 0;
    for (int i = 0; i < 50; i++) begin
      if (i < 20) begin dv2 = 1'b1; pix2 = 4'd3; end
      else begin
        dv2 = 1'($urandom_range(0, 1));
        case ($urandom_range(0, 2))
          0: pix2 = 4'd3;
          1: pix2 = 4'd5;
          default: pix2 = 4'd9;
        endcase
      end
      if (dv2) begin
        m2[pix2] = (m2[pix2] >= 15) ? 15 : m2[pix2] + 1;
        n2++;
      end
      @(negedge clk);
    end
    dv2 = 1'b0; vs2 = 1'b0; @(negedge clk); vs2 = 1'b1;
    t = 0;
    while (!done2 && t < 20) begin @(negedge clk); t++; end
    check("sat_done", done2, 1);
    check("sat_busy", busy2, 0);
    check("sat_pix_count", pix_count2, 64'(n2));
    for (int b = 0; b < 16; b++) read2({2'd0, 4'(b)}, 4'(m2[b]), 1'b0, $sformatf("sat_bin%0d", b));
    read2({2'd1, 4'd3}, 4'd0, 1'b1, "sat_lane1");

    capture(0, 64, 1'b1, 1'b0, "const");
    capture(1, 6, 1'b0, 1'b1, "fwd");
    capture(2, 150, 1'b0, 1'b0, "rand_a");
    capture(2, 90, 1'b1, 1'b0, "rand_b");

    // reset in the middle of a capture
    start = 1'b1; @(negedge clk); start = 1'b0;
    repeat (NB + 4) @(negedge clk);
    vs = 1'b1; @(negedge clk); vs = 1'b0; @(negedge clk);
    for (int i = 0; i < 20; i++) begin dv = 1'b1; pix = gen_pix(2, i); @(negedge clk); end
    dv = 1'b0; rst = 1'b1; @(negedge clk); rst = 1'b0;
    cnt = 0;
    while (busy && cnt < 400) begin cnt++; @(negedge clk); end
    check("midrst_clear_cycles", cnt, 256);
    check("midrst_done", done, 0);
    check("midrst_pix_count", pix_count, 0);
    model_clear();
    dump_check("midrst");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
